// File: rtl/reg_file_pip_if.sv
// Bundles the writeback bus, the decode read requests and the registered
// operands that pass between the pipeline and the integer register file.
interface reg_file_pip_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            wb_we;
   logic [AW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic            stall;
   logic            flush;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [AW-1:0]   rs1_idx_q;
   logic [AW-1:0]   rs2_idx_q;

   modport master (
      output wb_we, wb_rd, wb_data, rs1_addr, rs2_addr, stall, flush,
      input  rs1_data, rs2_data, rs1_idx_q, rs2_idx_q
   );

   modport slave (
      input  wb_we, wb_rd, wb_data, rs1_addr, rs2_addr, stall, flush,
      output rs1_data, rs2_data, rs1_idx_q, rs2_idx_q
   );
endinterface

// File: rtl/reg_file_pip.sv
// RV32I integer register file with write-through bypass, stall hold with
// writeback refresh of held operands, and flush-to-zero read outputs.
module reg_file_pip #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input logic          clk,
   input logic          rst_n,
   reg_file_pip_if.slave bus
);
   logic [XLEN-1:0] regs_r [NREGS];
   logic [XLEN-1:0] rs1_data_r, rs2_data_r;
   logic [AW-1:0]   rs1_idx_r, rs2_idx_r;
   logic [XLEN-1:0] rs1_data_s, rs2_data_s;
   logic [AW-1:0]   rs1_idx_s, rs2_idx_s;
   logic            wr_s;

   assign wr_s = bus.wb_we && (bus.wb_rd != {AW{1'b0}});

   // Register array write port; x0 is never written so it stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else begin
         if (wr_s) begin
            regs_r[bus.wb_rd] <= bus.wb_data;
         end
      end
   end

   // Next read-port state: flush beats stall; a stalled port only picks up a
   // writeback aimed at the index it is holding, so load-use stalls stay fresh.
   always_comb begin
      rs1_data_s = rs1_data_r;
      rs2_data_s = rs2_data_r;
      rs1_idx_s  = rs1_idx_r;
      rs2_idx_s  = rs2_idx_r;
      if (bus.flush) begin
         rs1_data_s = {XLEN{1'b0}};
         rs2_data_s = {XLEN{1'b0}};
         rs1_idx_s  = {AW{1'b0}};
         rs2_idx_s  = {AW{1'b0}};
      end else if (bus.stall) begin
         if (wr_s && (bus.wb_rd == rs1_idx_r)) begin
            rs1_data_s = bus.wb_data;
         end else begin
            rs1_data_s = rs1_data_r;
         end
         if (wr_s && (bus.wb_rd == rs2_idx_r)) begin
            rs2_data_s = bus.wb_data;
         end else begin
            rs2_data_s = rs2_data_r;
         end
      end else begin
         rs1_idx_s = bus.rs1_addr;
         rs2_idx_s = bus.rs2_addr;
         if (bus.rs1_addr == {AW{1'b0}}) begin
            rs1_data_s = {XLEN{1'b0}};
         end else if (wr_s && (bus.wb_rd == bus.rs1_addr)) begin
            rs1_data_s = bus.wb_data;
         end else begin
            rs1_data_s = regs_r[bus.rs1_addr];
         end
         if (bus.rs2_addr == {AW{1'b0}}) begin
            rs2_data_s = {XLEN{1'b0}};
         end else if (wr_s && (bus.wb_rd == bus.rs2_addr)) begin
            rs2_data_s = bus.wb_data;
         end else begin
            rs2_data_s = regs_r[bus.rs2_addr];
         end
      end
   end

   // Registered read-port outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_data_r <= {XLEN{1'b0}};
         rs2_data_r <= {XLEN{1'b0}};
         rs1_idx_r  <= {AW{1'b0}};
         rs2_idx_r  <= {AW{1'b0}};
      end else begin
         rs1_data_r <= rs1_data_s;
         rs2_data_r <= rs2_data_s;
         rs1_idx_r  <= rs1_idx_s;
         rs2_idx_r  <= rs2_idx_s;
      end
   end

   assign bus.rs1_data  = rs1_data_r;
   assign bus.rs2_data  = rs2_data_r;
   assign bus.rs1_idx_q = rs1_idx_r;
   assign bus.rs2_idx_q = rs2_idx_r;
endmodule
